// File: rtl/nrzi_unstuff_rx.sv
// USB receive front end: NRZI decode, bit unstuffing, EOP/line-error detect, LSB-first deserialiser.
// Define NRZI_UNSTUFF_EN to enable stuff-bit removal and stuff_err; otherwise every J/K bit is emitted.
module nrzi_unstuff_rx #(
    parameter int DATA_W      = 8,
    parameter int STUFF_LEN   = 6,
    parameter int EOP_SE0_MIN = 2
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              d_plus,
    input  logic              d_minus,
    input  logic              shift_enable,
    output logic              d_orig,
    output logic              bit_valid,
    output logic [DATA_W-1:0] word_data,
    output logic              word_valid,
    output logic              eop,
    output logic              stuff_err,
    output logic              line_err
);

    localparam int CW = $clog2(DATA_W);
    localparam int SW = $clog2(EOP_SE0_MIN + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
    localparam logic [SW-1:0] SE0_SAT  = SW'(EOP_SE0_MIN);

    logic              prev_level, prev_level_n;
    logic [CW-1:0]     bit_cnt, bit_cnt_n;
    logic [SW-1:0]     se0_cnt, se0_cnt_n;
    logic [DATA_W-1:0] sr, sr_n, word_n;
    logic              d_orig_n, bit_valid_n, word_valid_n;
    logic              eop_n, stuff_err_n, line_err_n;
    logic              se0, se1, level, dec_bit, emit;

`ifdef NRZI_UNSTUFF_EN
    localparam int OW = $clog2(STUFF_LEN + 1);
    localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LEN);
    logic [OW-1:0] ones_cnt, ones_cnt_n;
`endif

    // J is encoded as 1 so the level is simply d_plus
    assign se0     = !d_plus && !d_minus;
    assign se1     = d_plus && d_minus;
    assign level   = d_plus;
    assign dec_bit = (level == prev_level);

    always_comb begin
        prev_level_n = prev_level;
        bit_cnt_n    = bit_cnt;
        se0_cnt_n    = se0_cnt;
        sr_n         = sr;
        word_n       = word_data;
        d_orig_n     = d_orig;
        bit_valid_n  = 1'b0;
        word_valid_n = 1'b0;
        eop_n        = 1'b0;
        stuff_err_n  = 1'b0;
        line_err_n   = 1'b0;
        emit         = 1'b0;
`ifdef NRZI_UNSTUFF_EN
        ones_cnt_n   = ones_cnt;
`endif
        if (shift_enable) begin
            if (se1) begin
                line_err_n = 1'b1;
            end else if (se0) begin
                if (se0_cnt != SE0_SAT) se0_cnt_n = se0_cnt + 1'b1;
            end else if (se0_cnt != '0) begin
                // first J/K after an SE0 run: either a clean EOP or an error
                prev_level_n = level;
                bit_cnt_n    = '0;
                se0_cnt_n    = '0;
                sr_n         = '0;
`ifdef NRZI_UNSTUFF_EN
                ones_cnt_n   = '0;
`endif
                if (se0_cnt == SE0_SAT && level) eop_n = 1'b1;
                else line_err_n = 1'b1;
            end else begin
                prev_level_n = level;
`ifdef NRZI_UNSTUFF_EN
                if (ones_cnt == ONES_MAX) begin
                    ones_cnt_n = '0;
                    if (dec_bit) begin
                        stuff_err_n = 1'b1;
                        bit_cnt_n   = '0;
                        sr_n        = '0;
                    end
                end else begin
                    emit       = 1'b1;
                    ones_cnt_n = dec_bit ? ones_cnt + 1'b1 : '0;
                end
`else
                emit = 1'b1;
`endif
            end
        end
        if (emit) begin
            d_orig_n      = dec_bit;
            bit_valid_n   = 1'b1;
            sr_n[bit_cnt] = dec_bit;
            if (bit_cnt == LAST_BIT) begin
                word_n       = sr_n;
                word_valid_n = 1'b1;
                bit_cnt_n    = '0;
            end else begin
                bit_cnt_n = bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prev_level <= 1'b1;
            bit_cnt    <= '0;
            se0_cnt    <= '0;
            sr         <= '0;
            word_data  <= '0;
            d_orig     <= 1'b1;
            bit_valid  <= 1'b0;
            word_valid <= 1'b0;
            eop        <= 1'b0;
            stuff_err  <= 1'b0;
            line_err   <= 1'b0;
`ifdef NRZI_UNSTUFF_EN
            ones_cnt   <= '0;
`endif
        end else begin
            prev_level <= prev_level_n;
            bit_cnt    <= bit_cnt_n;
            se0_cnt    <= se0_cnt_n;
            sr         <= sr_n;
            word_data  <= word_n;
            d_orig     <= d_orig_n;
            bit_valid  <= bit_valid_n;
            word_valid <= word_valid_n;
            eop        <= eop_n;
            stuff_err  <= stuff_err_n;
            line_err   <= line_err_n;
`ifdef NRZI_UNSTUFF_EN
            ones_cnt   <= ones_cnt_n;
`endif
        end
    end

endmodule

// File: tb/tb_nrzi_unstuff_rx.sv
// Directed bench for nrzi_unstuff_rx: sync word, stuffing, EOP, line errors, async reset.
// Expectations follow NRZI_UNSTUFF_EN when it is defined for the build.
module tb_nrzi_unstuff_rx;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       d_plus = 1'b1;
    logic       d_minus = 1'b0;
    logic       shift_enable = 1'b0;
    logic       d_orig, bit_valid, word_valid, eop, stuff_err, line_err;
    logic [7:0] word_data;

    int n_chk = 0;
    int n_fail = 0;

    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;
    localparam logic [1:0] SE1 = 2'b11;

    // pulse vector order: {bit_valid, word_valid, eop, stuff_err, line_err}
    localparam logic [4:0] P_NONE = 5'b00000;
    localparam logic [4:0] P_BIT  = 5'b10000;
    localparam logic [4:0] P_WORD = 5'b11000;
    localparam logic [4:0] P_EOP  = 5'b00100;
    localparam logic [4:0] P_SERR = 5'b00010;
    localparam logic [4:0] P_LERR = 5'b00001;

    nrzi_unstuff_rx #(.DATA_W(8), .STUFF_LEN(6), .EOP_SE0_MIN(2)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .d_plus       (d_plus),
        .d_minus      (d_minus),
        .shift_enable (shift_enable),
        .d_orig       (d_orig),
        .bit_valid    (bit_valid),
        .word_data    (word_data),
        .word_valid   (word_valid),
        .eop          (eop),
        .stuff_err    (stuff_err),
        .line_err     (line_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
    endtask

    // one strobed sample; outputs are checked on the following falling edge
    task automatic step(input string tag, input logic [1:0] ls,
                        input logic [4:0] pulses, input logic bit_exp);
        @(negedge clk);
        {d_plus, d_minus} = ls;
        shift_enable = 1'b1;
        @(negedge clk);
        shift_enable = 1'b0;
        d_plus = 1'b1;
        d_minus = 1'b0;
        chk(tag, {27'd0, bit_valid, word_valid, eop, stuff_err, line_err},
            {27'd0, pulses});
        if (pulses[4]) chk({tag, "_bit"}, {31'd0, d_orig}, {31'd0, bit_exp});
    endtask

    // K,J,K,J,K,J,K,K from prev=J and an empty word gives 8'h80
    task automatic sync_word(input string tag);
        logic [1:0] seq [8];
        seq = '{K, J, K, J, K, J, K, K};
        for (int i = 0; i < 7; i++) step(tag, seq[i], P_BIT, 1'b0);
        step({tag, "_last"}, seq[7], P_WORD, 1'b1);
        chk({tag, "_word"}, {24'd0, word_data}, 32'h80);
    endtask

    initial begin
        do_reset();
        chk("reset_out",
            {26'd0, d_orig, bit_valid, word_valid, eop, stuff_err, line_err},
            32'b100000);
        chk("reset_word", {24'd0, word_data}, 32'h0);

        sync_word("sync");

        // six ones then a transition
        do_reset();
        for (int i = 0; i < 6; i++) step("stf_one", J, P_BIT, 1'b1);
`ifdef NRZI_UNSTUFF_EN
        step("stf_drop", K, P_NONE, 1'b0);
        step("stf_b6", J, P_BIT, 1'b0);
        step("stf_b7", J, P_WORD, 1'b1);
        chk("stf_word", {24'd0, word_data}, 32'hBF);
`else
        step("stf_b6", K, P_BIT, 1'b0);
        step("stf_b7", J, P_WORD, 1'b0);
        chk("stf_word", {24'd0, word_data}, 32'h3F);
        step("stf_b0", J, P_BIT, 1'b1);
`endif

        // seven same-level samples
        do_reset();
        for (int i = 0; i < 6; i++) step("serr_one", J, P_BIT, 1'b1);
`ifdef NRZI_UNSTUFF_EN
        step("serr_7th", J, P_SERR, 1'b0);
        sync_word("serr_restart");
`else
        step("nostf_7th", J, P_BIT, 1'b1);
        step("nostf_b7", K, P_WORD, 1'b0);
        chk("nostf_word", {24'd0, word_data}, 32'h7F);
`endif

        // EOP after a partial word
        do_reset();
        step("eop_b0", K, P_BIT, 1'b0);
        step("eop_b1", J, P_BIT, 1'b0);
        step("eop_b2", K, P_BIT, 1'b0);
        step("eop_se0a", SE0, P_NONE, 1'b0);
        step("eop_se0b", SE0, P_NONE, 1'b0);
        step("eop_j", J, P_EOP, 1'b0);
        step("eop_k0", K, P_BIT, 1'b0);
        for (int i = 0; i < 6; i++) step("eop_nx", (i % 2 == 0) ? J : K, P_BIT, 1'b0);
        step("eop_word", J, P_WORD, 1'b0);
        chk("eop_wdata", {24'd0, word_data}, 32'h00);

        // line errors
        do_reset();
        step("le_k", K, P_BIT, 1'b0);
        step("le_se0", SE0, P_NONE, 1'b0);
        step("le_short", K, P_LERR, 1'b0);
        step("le_j", J, P_BIT, 1'b0);
        step("le_se1", SE1, P_LERR, 1'b0);
        step("le_hold", J, P_BIT, 1'b1);
        step("le_se0a", SE0, P_NONE, 1'b0);
        step("le_se0b", SE0, P_NONE, 1'b0);
        step("le_kfull", K, P_LERR, 1'b0);
        step("le_after", K, P_BIT, 1'b1);

        // asynchronous reset in the middle of a word
        do_reset();
        step("rst_b0", K, P_BIT, 1'b0);
        step("rst_b1", J, P_BIT, 1'b0);
        step("rst_b2", K, P_BIT, 1'b0);
        step("rst_b3", J, P_BIT, 1'b0);
        @(negedge clk);
        {d_plus, d_minus} = K;
        shift_enable = 1'b1;
        @(negedge clk);
        shift_enable = 1'b0;
        chk("rst_pre", {30'd0, bit_valid, d_orig}, {30'd0, 2'b10});
        n_rst = 1'b0;
        #1;
        chk("rst_async",
            {26'd0, d_orig, bit_valid, word_valid, eop, stuff_err, line_err},
            32'b100000);
        chk("rst_async_word", {24'd0, word_data}, 32'h0);
        @(negedge clk);
        n_rst = 1'b1;
        sync_word("rst_restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/nrzi_unstuff_rx.md
# nrzi_unstuff_rx

Parametrised USB receive front end that replaces the single-bit NRZI decoder. The block samples the differential pair on a bit-rate strobe, decodes NRZI, and removes stuffed bits. It also detects EOP and illegal line states, and deserialises the recovered stream LSB-first into DATA_W-bit words. It sits between the bit-timing/synchroniser logic and the packet-level receive controller.

## Interface
- DATA_W, 8: deserialised word width (≥2)
- STUFF_LEN, 6: consecutive decoded 1s after which one stuffed 0 is expected (≥1)
- EOP_SE0_MIN, 2: minimum consecutive SE0 samples forming a valid EOP (≥1)

- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- d_plus  in  1  synchronised D+ line
- d_minus  in  1  synchronised D- line
- shift_enable  in  1  one-cycle bit-sample strobe from bit timer
- d_orig  out  1  last decoded (emitted) bit
- bit_valid  out  1  one-cycle pulse: d_orig holds a new emitted bit
- word_data  out  DATA_W  last completed word, first received bit in bit 0
- word_valid  out  1  one-cycle pulse: word_data updated
- eop  out  1  one-cycle pulse on valid end-of-packet
- stuff_err  out  1  one-cycle pulse on bit-stuff violation
- line_err  out  1  one-cycle pulse on SE1 or malformed SE0

## Operation
- Line state per sample: J = (1,0), K = (0,1), SE0 = (0,0), SE1 = (1,1).
- Register prev_level holds the last J/K level. Reset and post-EOP value is J.
- J/K sample with no SE0 run pending: decoded bit = 1 if the level equals prev_level, else 0. Then prev_level ← sampled level.
- Unstuffing: ones_cnt counts consecutive decoded 1s. A decoded 0 clears it.
  - When ones_cnt == STUFF_LEN, the next decoded bit is the stuff bit.
  - Stuff bit = 0: discarded, no bit_valid, ones_cnt ← 0.
  - Stuff bit = 1: stuff_err pulse, bit discarded, ones_cnt ← 0, bit_cnt ← 0, shift register cleared.
- Emitted bits shift into an internal register at position bit_cnt; bit_cnt increments.
  - At bit_cnt == DATA_W-1 the completed word is copied to word_data with word_valid, and bit_cnt ← 0.
- SE0 samples increment se0_cnt, saturating at EOP_SE0_MIN. No bit is emitted and prev_level is held.
- First J after se0_cnt ≥ EOP_SE0_MIN:
  - eop pulse.
  - prev_level ← J; ones_cnt, bit_cnt, se0_cnt ← 0.
  - Partial word discarded; no word_valid.
- J or K after an SE0 run shorter than EOP_SE0_MIN, or K after a full run:
  - line_err pulse, no bit emitted.
  - prev_level ← sampled level; all counters ← 0.
- SE1 sample: line_err pulse. All state unchanged, no bit emitted.
- No activity without shift_enable. All state holds.

## Timing
- All outputs are registered. Responses appear in the cycle after the cycle in which shift_enable is high.
- bit_valid and word_valid for the final bit of a word assert in the same cycle.
- Pulses (bit_valid, word_valid, eop, stuff_err, line_err) last exactly one cycle. They assert only in cycles following a shift_enable.
- Reset values: d_orig = 1, bit_valid = 0, word_data = 0, word_valid = 0, eop = 0, stuff_err = 0, line_err = 0. Internally prev_level = J and all counters = 0.
- Reset mid-word discards all partial state immediately and asynchronously.
- Counter widths: $clog2(DATA_W), $clog2(STUFF_LEN+1), $clog2(EOP_SE0_MIN+1).
- Back-to-back shift_enable on consecutive cycles is supported.

## Configuration
- NRZI_UNSTUFF_EN defined: unstuffing and stuff_err behave as above.
- Undefined:
  - Every decoded J/K bit is emitted.
  - ones_cnt logic is removed.
  - stuff_err is tied 0.

## Test plan
- SYNC: reset, then J/K samples K,J,K,J,K,J,K,K -> 8 bit_valid pulses, word_valid with word_data = 8'h80, no errors.
- Stuffing (macro defined): 6 same-level samples after a 1-run start, then a transition -> 6 bit_valid pulses of 1, no pulse for the stuffed 0, ones_cnt reset. Following bits continue the word.
- Stuff error: 7 consecutive same-level samples -> stuff_err on the 7th sample's response cycle, no 7th bit_valid, word restarts.
- EOP: 3 bits then SE0,SE0,J -> eop pulse one cycle after the J strobe, no word_valid. Next K decodes as 0.
- Line errors: single SE0 then K -> line_err, no bit. SE1 sample -> line_err with state unchanged.
- Reset mid-word, plus macro undefined: 5 bits, n_rst low -> outputs at reset values. With the macro undefined, 7 same-level samples -> 7 bit_valid pulses and stuff_err stays 0.
